// File: rtl/led_pio_pkg.sv
// led_pio_pkg: register map and INFO word layout shared by the LED PIO block.
package led_pio_pkg;
  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_SET          = 3'd1;
  localparam logic [2:0] ADDR_CLR          = 3'd2;
  localparam logic [2:0] ADDR_TGL          = 3'd3;
  localparam logic [2:0] ADDR_BLINK_EN     = 3'd4;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_PWM_DUTY     = 3'd6;
  localparam logic [2:0] ADDR_INFO         = 3'd7;

  typedef struct packed {
    logic [7:0] pwm_bits;
    logic [7:0] prescale_w;
    logic [7:0] rsvd;
    logic [7:0] width;
  } info_t;

  function automatic info_t info_word(input int width, input int prescale_w, input int pwm_bits);
    info_word = '{pwm_bits: 8'(pwm_bits), prescale_w: 8'(prescale_w), rsvd: 8'h00, width: 8'(width)};
  endfunction
endpackage

// File: rtl/led_pio_timebase.sv
// led_pio_timebase: blink prescaler and free-running PWM generator shared by all channels.
module led_pio_timebase
  import led_pio_pkg::*;
#(
  parameter int PRESCALE_W = 24,
  parameter int PWM_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] period_i,
  input  logic                  period_wr_i,
  input  logic [PWM_BITS:0]     duty_i,
  output logic                  blink_phase,
  output logic                  pwm_on
);
  logic [PRESCALE_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic                  idle, terminal;

  // A period write restarts the prescaler and beats a coincident terminal count.
  always_comb begin
    idle        = period_i == '0;
    terminal    = !idle && blink_cnt_q == period_i - PRESCALE_W'(1);
    blink_cnt_d = period_wr_i || idle || terminal ? '0 : blink_cnt_q + PRESCALE_W'(1);
    phase_d     = period_wr_i || idle ? 1'b1 : phase_q ^ terminal;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      pwm_cnt_q   <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  assign blink_phase = phase_q;
  assign pwm_on      = {1'b0, pwm_cnt_q} < duty_i;
endmodule

// File: rtl/led_pio_ctrl.sv
// led_pio_ctrl: Avalon-MM LED/PIO output port with set/clear/toggle, shared blink and PWM dimming.
module led_pio_ctrl
  import led_pio_pkg::*;
#(
  parameter int               WIDTH       = 21,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PRESCALE_W  = 24,
  parameter int               PWM_BITS    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  localparam info_t INFO = info_word(WIDTH, PRESCALE_W, PWM_BITS);

  logic [WIDTH-1:0]      data_q, data_d, blink_en_q, blink_en_d, out_q, out_d, wd;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PWM_BITS:0]     duty_q, duty_d;
  logic                  wr, period_wr, blink_phase, pwm_on;
  logic                  unused_wd;

  assign unused_wd = ^writedata;

  always_comb begin
    wr         = chipselect && !write_n;
    wd         = writedata[WIDTH-1:0];
    period_wr  = wr && address == ADDR_BLINK_PERIOD;
    data_d     = !wr                   ? data_q :
                 address == ADDR_DATA  ? wd :
                 address == ADDR_SET   ? data_q | wd :
                 address == ADDR_CLR   ? data_q & ~wd :
                 address == ADDR_TGL   ? data_q ^ wd : data_q;
    blink_en_d = wr && address == ADDR_BLINK_EN ? wd : blink_en_q;
    period_d   = period_wr ? writedata[PRESCALE_W-1:0] : period_q;
    duty_d     = wr && address == ADDR_PWM_DUTY ? writedata[PWM_BITS:0] : duty_q;
    out_d      = data_q & (~blink_en_q | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};
    readdata   = address == ADDR_INFO         ? 32'(INFO) :
                 address == ADDR_BLINK_EN     ? 32'(blink_en_q) :
                 address == ADDR_BLINK_PERIOD ? 32'(period_q) :
                 address == ADDR_PWM_DUTY     ? 32'(duty_q) : 32'(data_q);
  end

  // Duty resets to 2^PWM_BITS so channels come up fully on, undimmed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      period_q   <= '0;
      duty_q     <= {1'b1, {PWM_BITS{1'b0}}};
      out_q      <= RESET_VALUE;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      out_q      <= out_d;
    end
  end

  led_pio_timebase #(
    .PRESCALE_W(PRESCALE_W),
    .PWM_BITS  (PWM_BITS)
  ) u_timebase (
    .clk        (clk),
    .reset_n    (reset_n),
    .period_i   (period_q),
    .period_wr_i(period_wr),
    .duty_i     (duty_q),
    .blink_phase(blink_phase),
    .pwm_on     (pwm_on)
  );

  assign out_port = out_q;
endmodule

// File: tb/tb_led_pio_ctrl.sv
// tb_led_pio_ctrl: directed stimulus with a cycle-stamped scoreboard checked by a negedge monitor.
module tb_led_pio_ctrl;
  import led_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [20:0] out_port;

  typedef struct {
    int unsigned cyc;
    bit          rd;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned r = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] got;
  logic [31:0] duties [5] = '{32'd64, 32'd255, 32'd0, 32'd256, 32'd300};

  led_pio_ctrl #(.RESET_VALUE(21'h00055)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every expectation carries the cycle at which it must hold.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        got = sb[i].rd ? readdata : 32'(out_port);
        checks++;
        if (sb[i].cyc < cyc || got !== sb[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", sb[i].name, cyc, sb[i].cyc, got, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned d, input bit rd, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = cyc + d;
    e.rd = rd;
    e.exp = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic wr_raw(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n = wn;
    address = a;
    writedata = d;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_raw(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] v, input string n);
    address = a;
    push(0, 1'b1, v, n);
    tick();
  endtask

  task automatic eo(input int unsigned d, input logic [31:0] v, input string n);
    push(d, 1'b0, v, n);
  endtask

  initial begin
    tick();
    tick();
    eo(0, 32'h55, "rst_out");
    rd(ADDR_DATA, 32'h55, "rst_data");
    reset_n = 1'b1;
    r = cyc;
    rd(ADDR_INFO, 32'h08180015, "info");
    rd(ADDR_BLINK_EN, 32'h0, "rst_blink_en");
    rd(ADDR_BLINK_PERIOD, 32'h0, "rst_period");
    eo(0, 32'h55, "post_rst_out");
    rd(ADDR_PWM_DUTY, 32'h100, "rst_duty");

    wr(ADDR_DATA, 32'hFFFF_FFFF);
    wr(ADDR_CLR, 32'h0F);
    wr(ADDR_TGL, 32'h30);
    eo(0, 32'h001F_FFF0, "out_lag");
    eo(1, 32'h001F_FFC0, "out_tgl");
    rd(ADDR_DATA, 32'h001F_FFC0, "data_tgl");
    rd(ADDR_SET, 32'h001F_FFC0, "rd_set");
    rd(ADDR_CLR, 32'h001F_FFC0, "rd_clr");
    rd(ADDR_TGL, 32'h001F_FFC0, "rd_tgl");
    wr(ADDR_SET, 32'h0000_0005);
    rd(ADDR_DATA, 32'h001F_FFC5, "data_set");

    wr_raw(1'b0, 1'b0, ADDR_DATA, 32'h0);
    wr_raw(1'b1, 1'b1, ADDR_DATA, 32'h0);
    rd(ADDR_DATA, 32'h001F_FFC5, "ignored_wr");
    wr(ADDR_INFO, 32'h0);
    rd(ADDR_INFO, 32'h08180015, "info_ro");
    wr(ADDR_BLINK_EN, 32'hFFFF_FFFF);
    rd(ADDR_BLINK_EN, 32'h001F_FFFF, "blink_en_mask");
    wr(ADDR_BLINK_PERIOD, 32'hFFFF_FFFF);
    rd(ADDR_BLINK_PERIOD, 32'h00FF_FFFF, "period_mask");
    wr(ADDR_PWM_DUTY, 32'hFFFF_FFFF);
    rd(ADDR_PWM_DUTY, 32'h0000_01FF, "duty_mask");
    wr(ADDR_BLINK_EN, 32'h0);
    wr(ADDR_BLINK_PERIOD, 32'h0);
    wr(ADDR_PWM_DUTY, 32'h100);

    wr(ADDR_DATA, 32'h1);
    wr(ADDR_BLINK_EN, 32'h1);
    wr(ADDR_BLINK_PERIOD, 32'd4);
    for (int j = 0; j < 16; j++)
      eo(j, (j == 0 || ((j - 1) / 4) % 2 == 0) ? 32'h1 : 32'h0, "blink4");
    repeat (16) tick();
    wr(ADDR_BLINK_PERIOD, 32'd0);
    for (int j = 1; j <= 8; j++) eo(j, 32'h1, "blink_off");
    repeat (9) tick();

    wr(ADDR_BLINK_PERIOD, 32'd4);
    repeat (3) tick();
    wr(ADDR_BLINK_PERIOD, 32'd4);
    for (int j = 0; j <= 8; j++) eo(j, j < 5 ? 32'h1 : 32'h0, "tc_write_wins");
    repeat (9) tick();
    rd(ADDR_BLINK_PERIOD, 32'd4, "period_rd");
    wr(ADDR_BLINK_PERIOD, 32'd0);
    wr(ADDR_BLINK_EN, 32'h0);

    for (int k = 0; k < 5; k++) begin
      wr(ADDR_PWM_DUTY, duties[k]);
      for (int j = 1; j <= 256; j++)
        eo(j, ((cyc + j - 1 - r) % 256) < duties[k] ? 32'h1 : 32'h0, "pwm");
      repeat (257) tick();
    end

    wr(ADDR_DATA, 32'hAA0);
    wr(ADDR_BLINK_EN, 32'hFFF);
    wr(ADDR_BLINK_PERIOD, 32'd3);
    repeat (5) tick();
    reset_n = 1'b0;
    eo(0, 32'h55, "async_rst_out");
    rd(ADDR_BLINK_PERIOD, 32'h0, "rst2_period");
    rd(ADDR_PWM_DUTY, 32'h100, "rst2_duty");
    rd(ADDR_BLINK_EN, 32'h0, "rst2_blink_en");
    rd(ADDR_DATA, 32'h55, "rst2_data");
    reset_n = 1'b1;
    r = cyc;
    wr(ADDR_DATA, 32'h1);
    wr(ADDR_BLINK_EN, 32'h1);
    wr(ADDR_BLINK_PERIOD, 32'd2);
    for (int j = 0; j < 8; j++)
      eo(j, (j < 3 || ((j - 3) / 2) % 2 == 1) ? 32'h1 : 32'h0, "blink_after_rst");
    repeat (8) tick();

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      $display("FAIL drain pending=%0d required=0", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
